// File: rtl/adc_sample_source.sv
// rtl/adc_sample_source.sv - serial 10-bit ADC reader feeding the filter sample interface
module adc_sample_source #(
    parameter int DATA_BITS      = 10,
    parameter int CLK_DIV        = 4,
    parameter int SAMPLE_PERIOD  = 200,
    parameter int STARTUP_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 adc_miso,
    output logic                 adc_cs_n,
    output logic                 adc_sclk,
    output logic [DATA_BITS-1:0] x_adc,
    output logic                 sample_ready,
    output logic                 coefficients_ready,
    input  logic                 valid_out,
    output logic                 overrun
);
    localparam int SLOT  = 2 * CLK_DIV;
    localparam int PER_W = $clog2(SAMPLE_PERIOD + 1);
    localparam int SU_W  = $clog2(STARTUP_CYCLES + 1);
    localparam int PH_W  = $clog2(SLOT + 1);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [SU_W-1:0]  SU_LAST  = SU_W'(STARTUP_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SLOT - 1);
    localparam logic [PH_W-1:0]  PH_HIGH  = PH_W'(CLK_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    generate
        if (CLK_DIV < 1 || STARTUP_CYCLES < 1 ||
            SAMPLE_PERIOD < 2 * CLK_DIV * DATA_BITS + 4) begin : g_bad_params
            $error("adc_sample_source: invalid parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {ST_STARTUP, ST_IDLE, ST_CONVERT, ST_DONE} state_t;

    state_t               state, state_next;
    logic [SU_W-1:0]      startup_cnt;
    logic [PER_W-1:0]     period_cnt;
    logic [PH_W-1:0]      phase;
    logic [PH_W-1:0]      phase_next;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 pending;
    logic                 startup_done;
    logic                 start_conv;
    logic                 last_cycle;

    assign startup_done = (startup_cnt == SU_LAST);
    assign start_conv   = enable && coefficients_ready && (period_cnt == '0);
    assign last_cycle   = (phase == PH_LAST) && (bit_idx == BIT_LAST);
    assign phase_next   = (phase == PH_LAST) ? '0 : phase + PH_W'(1);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_STARTUP;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_STARTUP: if (startup_done) state_next = ST_IDLE;
            ST_IDLE:    if (start_conv)   state_next = ST_CONVERT;
            ST_CONVERT: if (last_cycle)   state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_STARTUP;
        endcase
    end

    // Free-running sample timer; zero while disabled so re-enabling starts at once.
    always_ff @(posedge clk) begin
        if (reset || state == ST_STARTUP || !enable) period_cnt <= '0;
        else if (period_cnt == PER_LAST)             period_cnt <= '0;
        else                                         period_cnt <= period_cnt + PER_W'(1);
    end

    // Outputs are registered one cycle ahead: sclk is loaded with the level of the next phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            startup_cnt        <= '0;
            coefficients_ready <= 1'b0;
            adc_cs_n           <= 1'b1;
            adc_sclk           <= 1'b0;
            phase              <= '0;
            bit_idx            <= '0;
            shift              <= '0;
            x_adc              <= '0;
            sample_ready       <= 1'b0;
        end else begin
            sample_ready <= 1'b0;
            case (state)
                ST_STARTUP: begin
                    if (startup_done) coefficients_ready <= 1'b1;
                    else              startup_cnt <= startup_cnt + SU_W'(1);
                end
                ST_IDLE: begin
                    if (start_conv) begin
                        adc_cs_n <= 1'b0;
                        adc_sclk <= 1'b0;
                        phase    <= '0;
                        bit_idx  <= '0;
                    end
                end
                ST_CONVERT: begin
                    if (last_cycle) begin
                        adc_cs_n     <= 1'b1;
                        adc_sclk     <= 1'b0;
                        x_adc        <= shift;
                        sample_ready <= 1'b1;
                    end else begin
                        phase    <= phase_next;
                        adc_sclk <= (phase_next >= PH_HIGH);
                        if (phase == PH_LAST) bit_idx <= bit_idx + BIT_W'(1);
                        if (phase_next == PH_HIGH) shift <= {shift[DATA_BITS-2:0], adc_miso};
                    end
                end
                default: ;
            endcase
        end
    end

    // A sample issued while the previous one is still unacknowledged is an overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else if (sample_ready) begin
            pending <= 1'b1;
            if (pending && !valid_out) overrun <= 1'b1;
        end else if (valid_out) begin
            pending <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adc_sample_source.sv
// tb/tb_adc_sample_source.sv - self-checking bench for adc_sample_source
module tb_adc_sample_source;
    localparam int D  = 10;
    localparam int C  = 2;
    localparam int SP = 60;
    localparam int S  = 16;
    localparam int N  = 2 * C * D;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b1;
    logic         adc_miso = 1'b0;
    logic         valid_out = 1'b0;
    logic         adc_cs_n, adc_sclk, sample_ready, coefficients_ready, overrun;
    logic [D-1:0] x_adc;

    always #5 clk = ~clk;

    adc_sample_source #(
        .DATA_BITS(D), .CLK_DIV(C), .SAMPLE_PERIOD(SP), .STARTUP_CYCLES(S)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .adc_miso(adc_miso),
        .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .x_adc(x_adc),
        .sample_ready(sample_ready), .coefficients_ready(coefficients_ready),
        .valid_out(valid_out), .overrun(overrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference state: ADC word queues, per-conversion counters, pending/overrun model.
    logic [D-1:0] words[$];
    logic [D-1:0] exp_words[$];
    logic [D-1:0] cur_word = '0;
    logic [D-1:0] held_x = '0;
    int  cyc = 0, low_len = 0, rises = 0, last_ready = -1, ack_mode = 0, ack_delay = 1;
    bit  check_period = 0, pending = 0, exp_ov = 0, cs_fell = 0;
    logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_ready = 1'b0;

    task automatic step();
        logic cur_ready, cur_valid, cur_reset;
        logic [D-1:0] w;
        cur_ready = prev_ready;
        cur_valid = valid_out;
        cur_reset = reset;
        @(posedge clk);
        #1;
        cyc++;
        cs_fell = 0;
        if (cur_reset) begin
            exp_words.delete();
            held_x = '0; pending = 0; exp_ov = 0;
            last_ready = -1; low_len = 0; rises = 0;
        end else if (cur_ready) begin
            if (pending && !cur_valid) exp_ov = 1;
            pending = 1;
            check("overrun", overrun, exp_ov);
            check("ready_pulse", sample_ready, 0);
        end else if (cur_valid) begin
            pending = 0;
        end
        if (prev_cs === 1'b1 && adc_cs_n === 1'b0) begin
            cs_fell = 1;
            cur_word = (words.size() > 0) ? words.pop_front() : D'($urandom);
            exp_words.push_back(cur_word);
            rises = 0;
            low_len = 0;
        end
        if (adc_cs_n === 1'b0) begin
            low_len++;
            if (adc_sclk === 1'b1 && prev_sclk !== 1'b1) rises++;
        end
        adc_miso = (rises < D) ? cur_word[D-1-rises] : 1'b0;
        if (sample_ready === 1'b1) begin
            check("ready_cs_n", adc_cs_n, 1);
            check("cs_low_before_ready", prev_cs, 0);
            check("cs_low_len", low_len, N);
            check("sclk_rises", rises, D);
            if (exp_words.size() > 0) begin
                w = exp_words.pop_front();
                check("x_adc", x_adc, w);
                held_x = w;
            end else begin
                check("spurious_ready", sample_ready, 0);
            end
            if (check_period && last_ready >= 0) check("ready_spacing", cyc - last_ready, SP);
            last_ready = cyc;
            low_len = 0;
            ack_delay = $urandom_range(1, 55);
        end else begin
            check("x_hold", x_adc, held_x);
        end
        case (ack_mode)
            0:       valid_out = 1'b0;
            1:       valid_out = (last_ready >= 0 && cyc == last_ready + ack_delay);
            2:       valid_out = (sample_ready === 1'b1);
            default: valid_out = ($urandom_range(0, 3) == 0);
        endcase
        prev_cs = adc_cs_n;
        prev_sclk = adc_sclk;
        prev_ready = sample_ready;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (sample_ready !== 1'b1 && n < budget);
        if (sample_ready !== 1'b1) check("wait_ready_timeout", sample_ready, 1);
    endtask

    task automatic wait_cs_fall(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!cs_fell && n < budget);
        if (!cs_fell) check("wait_cs_timeout", cs_fell, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        check("rst_cs_n", adc_cs_n, 1);
        check("rst_sclk", adc_sclk, 0);
        check("rst_x_adc", x_adc, 0);
        check("rst_ready", sample_ready, 0);
        check("rst_coeff", coefficients_ready, 0);
        check("rst_overrun", overrun, 0);
        step();
        step();
        reset = 1'b0;
        for (int i = 1; i <= S; i++) begin
            step();
            if (i < S) begin
                check("coeff_early", coefficients_ready, 0);
                check("cs_startup", adc_cs_n, 1);
                check("sclk_startup", adc_sclk, 0);
            end else begin
                check("coeff_rise", coefficients_ready, 1);
            end
        end
    endtask

    initial begin
        do_reset();
        words.push_back(10'h2A5);
        words.push_back(10'h000);
        words.push_back(10'h3FF);
        check_period = 1;

        wait_ready(200);
        check("t2_x_adc", x_adc, 10'h2A5);
        step();
        check("ovr_after_first", overrun, 0);
        wait_ready(200);
        check("t3_x_zero", x_adc, 10'h000);
        wait_ready(200);
        check("t3_x_ones", x_adc, 10'h3FF);
        step();
        check("ovr_after_second", overrun, 1);

        wait_cs_fall(200);
        repeat (19) step();
        do_reset();

        ack_mode = 1;
        repeat (3) wait_ready(200);
        step();
        check("ovr_pulsed_ack", overrun, 0);

        ack_mode = 2;
        repeat (3) wait_ready(200);
        step();
        check("ovr_coincident_ack", overrun, 0);

        check_period = 0;
        wait_cs_fall(200);
        repeat (9) step();
        enable = 1'b0;
        wait_ready(200);
        begin
            int lows = 0;
            repeat (80) begin
                step();
                if (adc_cs_n !== 1'b1) lows++;
            end
            check("cs_idle_disabled", lows, 0);
        end
        enable = 1'b1;
        step();
        check("restart_cs_n", adc_cs_n, 0);

        last_ready = -1;
        check_period = 1;
        ack_mode = 3;
        repeat (8) wait_ready(200);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_sample_source.md
# adc_sample_source

Producer side of the filter's sample interface. Runs a serial read from a 10-bit ADC at a fixed sample rate, deserializes each conversion, and presents it on `x_adc` with a one-cycle `sample_ready` strobe. It also raises `coefficients_ready` once after start-up, since the filter taps are constants. It tracks the filter's `valid_out` to flag samples issued before the previous one was consumed.

## Interface
- `DATA_BITS`, 10: ADC word width; matches filter `x_adc`.
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period; must be ≥ 1.
- `SAMPLE_PERIOD`, 200: `clk` cycles between conversion starts; elaboration assertion requires ≥ 2·CLK_DIV·DATA_BITS + 4.
- `STARTUP_CYCLES`, 16: cycles after reset release before `coefficients_ready` asserts; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  permits new conversions.
- `adc_miso`  in  1  ADC serial data, MSB first.
- `adc_cs_n`  out  1  ADC chip select, active low.
- `adc_sclk`  out  1  ADC serial clock, idles low.
- `x_adc`  out  DATA_BITS  last captured sample, held until next capture.
- `sample_ready`  out  1  one-cycle strobe; `x_adc` is valid in the same cycle.
- `coefficients_ready`  out  1  level; high from end of start-up until reset.
- `valid_out`  in  1  filter output strobe; acknowledges the oldest pending sample.
- `overrun`  out  1  sticky error flag.

## Operation
- Reset values: `adc_cs_n`=1, `adc_sclk`=0, `x_adc`=0, `sample_ready`=0, `coefficients_ready`=0, `overrun`=0, state=STARTUP, all counters 0.
- STARTUP: counts `STARTUP_CYCLES`, then sets `coefficients_ready`=1 and goes to IDLE. `enable` is ignored in STARTUP.
- Period counter (IDLE/CONVERT/DONE):
  - While `enable`=1, increments modulo SAMPLE_PERIOD every cycle.
  - While `enable`=0, forced to 0.
- IDLE → CONVERT: when `enable`=1, `coefficients_ready`=1, and the period counter is 0. The first conversion therefore starts on the first enabled cycle.
- CONVERT:
  - `adc_cs_n`=0.
  - DATA_BITS bit slots, each 2·CLK_DIV cycles: `adc_sclk` low for the first CLK_DIV cycles, high for the last CLK_DIV cycles.
  - `adc_miso` is shifted in, MSB first, on the clk edge where `adc_sclk` goes 0→1.
  - After the last slot, `adc_cs_n`=1 and `adc_sclk`=0, then go to DONE.
- DONE (one cycle): load the shift register into `x_adc`, pulse `sample_ready`=1, return to IDLE.
- Deasserting `enable` during CONVERT does not abort it. The conversion and its `sample_ready` complete, and no new conversion starts until `enable` returns.
- Overrun tracking uses an internal `pending` bit:
  - Set on `sample_ready`.
  - Cleared on `valid_out` when no `sample_ready` occurs in the same cycle.
  - `sample_ready` while `pending`=1 and `valid_out`=0 sets `overrun`. `overrun` clears only on reset.
  - `valid_out` and `sample_ready` in the same cycle: no overrun, and `pending` stays 1.
  - `valid_out` while `pending`=0 is ignored.

## Timing
- Conversion-start cycle T has period counter = 0. `adc_cs_n` is low from T+1 through T+2·CLK_DIV·DATA_BITS, which is exactly 2·CLK_DIV·DATA_BITS cycles.
- `adc_sclk` produces exactly DATA_BITS rising edges per conversion, all while `adc_cs_n`=0.
- `sample_ready` asserts in cycle T+2·CLK_DIV·DATA_BITS+1, the first cycle with `adc_cs_n` high again.
- With `enable` held high, `sample_ready` pulses are spaced exactly SAMPLE_PERIOD cycles apart.
- `coefficients_ready` rises STARTUP_CYCLES cycles after the first cycle with `reset`=0.
- Reset asserted in any state: all outputs take their reset values on the next edge, and the in-flight conversion is discarded with no `sample_ready`.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Test plan
All scenarios use DATA_BITS=10, CLK_DIV=2, SAMPLE_PERIOD=60, STARTUP_CYCLES=16.
1. Release reset with `enable`=1 → `coefficients_ready` rises 16 cycles later; `adc_cs_n` stays 1 and `adc_sclk` stays 0 before that point.
2. ADC model drives 10'h2A5 MSB first → `adc_cs_n` low for exactly 40 cycles with 10 `adc_sclk` rising edges; in the next cycle `sample_ready`=1 for one cycle and `x_adc`=10'h2A5.
3. Hold `enable`=1 with ADC words 10'h000 then 10'h3FF → `sample_ready` pulses exactly 60 cycles apart with `x_adc` = 0x000 then 0x3FF; `x_adc` is held between pulses.
4. Three cases:
   - `valid_out` held 0 → `overrun` sets on the second `sample_ready`.
   - `valid_out` pulsed between samples → `overrun` stays 0.
   - `valid_out` coincident with `sample_ready` → `overrun` stays 0.
5. Drop `enable` 10 cycles into a conversion → the conversion completes, `sample_ready` fires, and `adc_cs_n` stays high afterward; re-raising `enable` starts a conversion on that cycle.
6. Assert `reset` 20 cycles into a conversion → next cycle `adc_cs_n`=1, `adc_sclk`=0, `x_adc`=0, `coefficients_ready`=0, `overrun`=0, and no `sample_ready`; the start-up sequence then repeats.
